muldiv_seq: RTL and testbench

Sequencer for the multicycle CPU's multiply and divide units and the Hi/Lo registers. It accepts a one-cycle request from the main control unit and issues the start pulses to the multiplier and divider. It holds the operand and result muxes stable while the units run, then writes Hi/Lo or raises a divide exception. The main control unit stalls on `busy` and resumes on `done`.

---
 rtl/muldiv_pkg.sv | 31 +++
 rtl/muldiv_cnt.sv | 37 +++
 rtl/muldiv_seq.sv | 175 +++++++++++++++++
 tb/tb_muldiv_seq.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the multiply/divide sequencer.
package muldiv_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_MUL_RUN = 3'd1,
        ST_DIV_RUN = 3'd2,
        ST_WRITE   = 3'd3,
        ST_EXCPT   = 3'd4
    } state_t;

    localparam logic [1:0] OP_MULT = 2'b00;
    localparam logic [1:0] OP_DIV  = 2'b01;
    localparam logic [1:0] OP_DIVM = 2'b10;
    localparam logic [1:0] OP_RSVD = 2'b11;

    localparam int MULT_CYCLES_DEF = 33;
    localparam int DIV_TIMEOUT_DEF = 40;

    // Counter width large enough for both the mult latency and the div timeout.
    function automatic int cnt_width(input int mult_cycles, input int div_timeout);
        int max_v;
        if (mult_cycles > div_timeout) begin
            max_v = mult_cycles;
        end else begin
            max_v = div_timeout;
        end
        return $clog2(max_v + 1);
    endfunction

endpackage

// File: rtl/muldiv_cnt.sv
// Loadable up/down counter shared by the mult latency count and div timeout.
// o_zero flags a count of zero, o_tc flags the terminal count TC.
module muldiv_cnt #(
    parameter int W  = 6,
    parameter int TC = 39
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    input  logic         i_up,
    output logic         o_zero,
    output logic         o_tc
);

    logic [W-1:0] r_count;

    // Load wins over counting; direction chosen by i_up.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= {W{1'b0}};
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en) begin
            if (i_up) begin
                r_count <= r_count + W'(1);
            end else begin
                r_count <= r_count - W'(1);
            end
        end
    end

    assign o_zero = (r_count == {W{1'b0}});
    assign o_tc   = (r_count == W'(TC));

endmodule

// File: rtl/muldiv_seq.sv
// Sequencer for the multiply/divide units and Hi/Lo write-back.
// Optional feature: define MULDIV_ZERO_PRECHECK_EN to trap a zero divisor at
// accept time without starting the divider.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_TIMEOUT = DIV_TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] divisor,
    input  logic        div_end,
    input  logic        DIVQ,
    output logic        mult_ctrl,
    output logic        div_ctrl,
    output logic        DIVASelect,
    output logic        DIVBSelect,
    output logic        MDSelect,
    output logic        HiCtrl,
    output logic        LoCtrl,
    output logic        busy,
    output logic        done,
    output logic        div_zero_excpt,
    output logic        md_timeout
);

    localparam int CNT_W = cnt_width(MULT_CYCLES, DIV_TIMEOUT);

    state_t r_state;
    logic   r_mult_ctrl;
    logic   r_div_ctrl;
    logic   r_sel_mdr;
    logic   r_sel_mult;
    logic   r_hilo_wr;
    logic   r_done;
    logic   r_zero;
    logic   r_tmo;

    logic             w_cnt_load;
    logic [CNT_W-1:0] w_cnt_load_val;
    logic             w_cnt_en;
    logic             w_cnt_up;
    logic             w_cnt_zero;
    logic             w_cnt_tc;
    logic             w_pre_zero;

`ifdef MULDIV_ZERO_PRECHECK_EN
    assign w_pre_zero = (divisor == 32'd0);
`else
    logic w_unused_divisor;
    assign w_unused_divisor = ^divisor;
    assign w_pre_zero       = 1'b0;
`endif

    // Counter control: load on any IDLE request, count down for mult, up for div.
    always_comb begin
        w_cnt_load = (r_state == ST_IDLE) && start;
        if (op == OP_MULT) begin
            w_cnt_load_val = CNT_W'(MULT_CYCLES - 1);
        end else begin
            w_cnt_load_val = {CNT_W{1'b0}};
        end
        w_cnt_en = (r_state == ST_MUL_RUN) || (r_state == ST_DIV_RUN);
        w_cnt_up = (r_state == ST_DIV_RUN);
    end

    muldiv_cnt #(
        .W  (CNT_W),
        .TC (DIV_TIMEOUT - 1)
    ) u_cnt (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_cnt_load),
        .i_load_val (w_cnt_load_val),
        .i_en       (w_cnt_en),
        .i_up       (w_cnt_up),
        .o_zero     (w_cnt_zero),
        .o_tc       (w_cnt_tc)
    );

    // Main FSM with registered pulse outputs and latched operand selects.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_mult_ctrl <= 1'b0;
            r_div_ctrl  <= 1'b0;
            r_sel_mdr   <= 1'b0;
            r_sel_mult  <= 1'b0;
            r_hilo_wr   <= 1'b0;
            r_done      <= 1'b0;
            r_zero      <= 1'b0;
            r_tmo       <= 1'b0;
        end else begin
            r_mult_ctrl <= 1'b0;
            r_div_ctrl  <= 1'b0;
            r_hilo_wr   <= 1'b0;
            r_done      <= 1'b0;
            r_zero      <= 1'b0;
            r_tmo       <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        case (op)
                            OP_MULT: begin
                                r_sel_mult  <= 1'b1;
                                r_sel_mdr   <= 1'b0;
                                r_mult_ctrl <= 1'b1;
                                r_state     <= ST_MUL_RUN;
                            end
                            OP_DIV, OP_DIVM: begin
                                r_sel_mult <= 1'b0;
                                r_sel_mdr  <= (op == OP_DIVM);
                                if (w_pre_zero) begin
                                    r_zero  <= 1'b1;
                                    r_done  <= 1'b1;
                                    r_state <= ST_EXCPT;
                                end else begin
                                    r_div_ctrl <= 1'b1;
                                    r_state    <= ST_DIV_RUN;
                                end
                            end
                            OP_RSVD: r_state <= ST_IDLE;
                            default: r_state <= ST_IDLE;
                        endcase
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_MUL_RUN: begin
                    if (w_cnt_zero) begin
                        r_hilo_wr <= 1'b1;
                        r_done    <= 1'b1;
                        r_state   <= ST_WRITE;
                    end
                end
                ST_DIV_RUN: begin
                    // The start-pulse cycle still sees the previous div_end.
                    if (!r_div_ctrl && div_end) begin
                        r_done <= 1'b1;
                        if (DIVQ) begin
                            r_zero  <= 1'b1;
                            r_state <= ST_EXCPT;
                        end else begin
                            r_hilo_wr <= 1'b1;
                            r_state   <= ST_WRITE;
                        end
                    end else if (w_cnt_tc) begin
                        r_tmo   <= 1'b1;
                        r_done  <= 1'b1;
                        r_state <= ST_EXCPT;
                    end
                end
                ST_WRITE: r_state <= ST_IDLE;
                ST_EXCPT: r_state <= ST_IDLE;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

    assign mult_ctrl      = r_mult_ctrl;
    assign div_ctrl       = r_div_ctrl;
    assign DIVASelect     = r_sel_mdr;
    assign DIVBSelect     = r_sel_mdr;
    assign MDSelect       = r_sel_mult;
    assign HiCtrl         = r_hilo_wr;
    assign LoCtrl         = r_hilo_wr;
    assign busy           = (r_state != ST_IDLE);
    assign done           = r_done;
    assign div_zero_excpt = r_zero;
    assign md_timeout     = r_tmo;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed table, reset abort, random mix.
module tb_muldiv_seq;

    localparam int MC = 33;
    localparam int TO = 40;
    localparam int K_NONE = 0;
    localparam int K_WR   = 1;
    localparam int K_ZERO = 2;
    localparam int K_TMO  = 3;

    logic        clk = 1'b0;
    logic        reset, start, div_end, DIVQ;
    logic [1:0]  op;
    logic [31:0] divisor;
    logic        mult_ctrl, div_ctrl, DIVASelect, DIVBSelect, MDSelect;
    logic        HiCtrl, LoCtrl, busy, done, div_zero_excpt, md_timeout;

    int   n_checks = 0;
    int   n_errors = 0;
    logic exp_md_sel = 1'b0;
    logic exp_ab_sel = 1'b0;

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] divisor;
        int          end_cyc;
        logic        divq;
        int          s1;
        int          s2;
        int          trail;
        int          exp_d;
        int          exp_kind;
    } vec_t;

    vec_t tbl[10];

    always #5 clk = ~clk;

    muldiv_seq #(.MULT_CYCLES(MC), .DIV_TIMEOUT(TO)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .op             (op),
        .divisor        (divisor),
        .div_end        (div_end),
        .DIVQ           (DIVQ),
        .mult_ctrl      (mult_ctrl),
        .div_ctrl       (div_ctrl),
        .DIVASelect     (DIVASelect),
        .DIVBSelect     (DIVBSelect),
        .MDSelect       (MDSelect),
        .HiCtrl         (HiCtrl),
        .LoCtrl         (LoCtrl),
        .busy           (busy),
        .done           (done),
        .div_zero_excpt (div_zero_excpt),
        .md_timeout     (md_timeout)
    );

    // Bit order: mult_ctrl div_ctrl DIVASel DIVBSel MDSel Hi Lo busy done zero tmo
    function automatic logic [10:0] act_vec();
        return {mult_ctrl, div_ctrl, DIVASelect, DIVBSelect, MDSelect,
                HiCtrl, LoCtrl, busy, done, div_zero_excpt, md_timeout};
    endfunction

    // Expected outputs in cycle c of a transaction that completes in cycle d.
    function automatic logic [10:0] exp_vec(input int c, input logic [1:0] t_op,
                                            input int d, input int kind);
        logic is_mult;
        logic is_div;
        is_mult = (t_op == 2'b00);
        is_div  = (t_op == 2'b01) || (t_op == 2'b10);
        return {is_mult && (c == 1),
                is_div && (c == 1) && (d > 1),
                exp_ab_sel, exp_ab_sel, exp_md_sel,
                (kind == K_WR) && (c == d),
                (kind == K_WR) && (c == d),
                (c >= 1) && (c <= d),
                (kind != K_NONE) && (c == d),
                (kind == K_ZERO) && (c == d),
                (kind == K_TMO) && (c == d)};
    endfunction

    // Transaction-level reference: completion cycle and outcome kind.
    function automatic void ref_result(input logic [1:0] t_op, input logic [31:0] t_div,
                                       input int t_end, input logic t_divq,
                                       output int d, output int kind);
        bit pre;
        pre = 1'b0;
`ifdef MULDIV_ZERO_PRECHECK_EN
        pre = 1'b1;
`endif
        if (t_op == 2'b00) begin
            d = MC + 1; kind = K_WR;
        end else if (t_op == 2'b11) begin
            d = 0; kind = K_NONE;
        end else if (pre && (t_div == 32'd0)) begin
            d = 1; kind = K_ZERO;
        end else if ((t_end >= 2) && (t_end <= TO)) begin
            d = t_end + 1; kind = t_divq ? K_ZERO : K_WR;
        end else begin
            d = TO + 1; kind = K_TMO;
        end
    endfunction

    task automatic check(input string name, input int c, input logic [10:0] got,
                         input logic [10:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s cycle %0d: got %b want %b", name, c, got, want);
        end
    endtask

    // Entered at a negedge in cycle 0; leaves at the negedge of cycle d+trail+1.
    task automatic run_txn(input string name, input logic [1:0] t_op, input logic [31:0] t_div,
                           input int t_end, input logic t_divq, input int t_s1, input int t_s2,
                           input int d, input int kind, input int trail);
        start   = 1'b1;
        op      = t_op;
        divisor = t_div;
        div_end = 1'b0;
        DIVQ    = t_divq;
        @(negedge clk);
        start = 1'b0;
        if (t_op != 2'b11) begin
            exp_md_sel = (t_op == 2'b00);
            exp_ab_sel = (t_op == 2'b10);
        end
        for (int c = 1; c <= d + trail; c++) begin
            check(name, c, act_vec(), exp_vec(c, t_op, d, kind));
            div_end = (c == t_end);
            start   = (c == t_s1) || (c == t_s2);
            if (start) op = 2'($urandom_range(0, 3));
            @(negedge clk);
        end
        div_end = 1'b0;
        start   = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          d, kind, trail, s1, e;
        logic [1:0]  r_op;
        logic [31:0] r_div;
        logic        r_q;

        reset = 1'b1; start = 1'b0; op = 2'b00; divisor = 32'd0;
        div_end = 1'b0; DIVQ = 1'b0;
        repeat (2) @(negedge clk);
        check("reset", 0, act_vec(), 11'b0);
        reset = 1'b0;
        @(negedge clk);
        check("post_reset", 0, act_vec(), 11'b0);

        tbl[0] = '{"mult",        2'b00, 32'd5, -1, 1'b0, -1, -1, 1, 34, K_WR};
        tbl[1] = '{"divm_end10",  2'b10, 32'd9, 10, 1'b0, -1, -1, 0, 11, K_WR};
`ifdef MULDIV_ZERO_PRECHECK_EN
        tbl[2] = '{"div_zero",    2'b01, 32'd0,  6, 1'b1, -1, -1, 2,  1, K_ZERO};
`else
        tbl[2] = '{"div_zero",    2'b01, 32'd0,  6, 1'b1, -1, -1, 2,  7, K_ZERO};
`endif
        tbl[3] = '{"div_timeout", 2'b01, 32'd3, -1, 1'b0, -1, -1, 2, 41, K_TMO};
        tbl[4] = '{"mult_ignore", 2'b00, 32'd0, -1, 1'b0,  5, 20, 1, 34, K_WR};
        tbl[5] = '{"rsvd",        2'b11, 32'd0, -1, 1'b0, -1, -1, 2,  0, K_NONE};
        tbl[6] = '{"div_stale",   2'b01, 32'd4,  1, 1'b0, -1, -1, 1, 41, K_TMO};
        tbl[7] = '{"div_end2",    2'b01, 32'd4,  2, 1'b0, -1, -1, 0,  3, K_WR};
        tbl[8] = '{"divm_end40",  2'b10, 32'd4, 40, 1'b0, -1, -1, 1, 41, K_WR};
        tbl[9] = '{"divm_late",   2'b10, 32'd4, 41, 1'b0, -1, -1, 1, 41, K_TMO};

        foreach (tbl[i]) begin
            run_txn(tbl[i].name, tbl[i].op, tbl[i].divisor, tbl[i].end_cyc, tbl[i].divq,
                    tbl[i].s1, tbl[i].s2, tbl[i].exp_d, tbl[i].exp_kind, tbl[i].trail);
        end

        // Asynchronous reset in cycle 15 of a MULT aborts it cleanly.
        start = 1'b1; op = 2'b00;
        @(negedge clk);
        start = 1'b0; exp_md_sel = 1'b1; exp_ab_sel = 1'b0;
        for (int c = 1; c < 15; c++) begin
            check("rst_mult", c, act_vec(), exp_vec(c, 2'b00, MC + 1, K_WR));
            @(negedge clk);
        end
        #1 reset = 1'b1;
        #1 check("rst_async", 15, act_vec(), 11'b0);
        @(negedge clk);
        reset = 1'b0; exp_md_sel = 1'b0; exp_ab_sel = 1'b0;
        for (int c = 0; c < 40; c++) begin
            check("rst_quiet", c, act_vec(), 11'b0);
            @(negedge clk);
        end
        run_txn("rst_new_mult", 2'b00, 32'd1, -1, 1'b0, -1, -1, MC + 1, K_WR, 1);

        // Random mix against the transaction-level reference.
        for (int i = 0; i < 40; i++) begin
            r_op  = 2'($urandom_range(0, 3));
            r_div = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom);
            e     = int'($urandom_range(0, TO + 3));
            r_q   = 1'($urandom_range(0, 1));
            ref_result(r_op, r_div, e, r_q, d, kind);
            trail = int'($urandom_range(0, 2));
            if (d == 0) trail = trail + 1;
            s1 = -1;
            if ((d >= 1) && ($urandom_range(0, 1) == 1)) s1 = int'($urandom_range(1, d));
            run_txn($sformatf("rnd%0d", i), r_op, r_div, e, r_q, s1, -1, d, kind, trail);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
